// File: rtl/snake_pkg.sv
// Shared display constants and pointer-latch FSM encoding for the snake game
// video pipeline.
package snake_pkg;

  localparam int unsigned COORD_W    = 12;
  localparam int unsigned H_ACTIVE   = 1024;
  localparam int unsigned V_ACTIVE   = 768;
  localparam int unsigned CELL_SHIFT = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } latch_state_e;

endpackage

// File: rtl/mouse_clamp.sv
// Clamps one raw pointer coordinate to the visible range and derives the
// snake-grid cell index from the clamped value.
module mouse_clamp
  import snake_pkg::*;
#(
  parameter int unsigned LIMIT = H_ACTIVE
) (
  input  logic [11:0] raw_i,
  output logic [11:0] clamped_o,
  output logic [11:0] cell_o
);

  localparam logic [11:0] MAX_COORD = 12'(LIMIT - 1);

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    clamped_o = (raw_i > MAX_COORD) ? MAX_COORD : raw_i;
    cell_o    = clamped_o >> CELL_SHIFT;
  end

endmodule

// File: rtl/mouse_frame_latch.sv
// Holds the latest mouse sample in a shadow register and commits it, clamped,
// once per frame at vertical-blank onset; also emits a per-frame click pulse.
module mouse_frame_latch
  import snake_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] mouse_x_i,
  input  logic [11:0] mouse_y_i,
  input  logic        mouse_valid_i,
  input  logic        mouse_left_i,
  input  logic        vblnk_i,
  output logic [11:0] x_o,
  output logic [11:0] y_o,
  output logic [11:0] cell_x_o,
  output logic [11:0] cell_y_o,
  output logic        click_o
);

  latch_state_e state_q, state_d;
  logic [11:0]  shadow_x_q, shadow_y_q;
  logic [11:0]  x_q, y_q, cell_x_q, cell_y_q;
  logic         vblnk_q, prev_left_q, press_q, press_d, click_q;
  logic         vblank_rise, press_edge, commit;
  logic [11:0]  clamp_x, clamp_y, clamp_cell_x, clamp_cell_y;

  assign vblank_rise = vblnk_i & ~vblnk_q;
  assign press_edge  = mouse_valid_i & mouse_left_i & ~prev_left_q;

  mouse_clamp #(.LIMIT(H_ACTIVE)) u_clamp_x (
    .raw_i     (shadow_x_q),
    .clamped_o (clamp_x),
    .cell_o    (clamp_cell_x)
  );

  mouse_clamp #(.LIMIT(V_ACTIVE)) u_clamp_y (
    .raw_i     (shadow_y_q),
    .clamped_o (clamp_y),
    .cell_o    (clamp_cell_y)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A new sample always (re)arms the latch, even in the commit cycle, so it lands next frame.
  always_comb begin
    state_d = state_q;
    if (mouse_valid_i) begin
      state_d = PENDING;
    end else if (state_q == PENDING && vblank_rise) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    commit = (state_q == PENDING) && vblank_rise;
  end

  // Clear-then-set ordering keeps a press in the blank-onset cycle for the next frame.
  always_comb begin
    press_d = press_q;
    if (vblank_rise) begin
      press_d = 1'b0;
    end
    if (press_edge) begin
      press_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q     <= 1'b0;
      shadow_x_q  <= '0;
      shadow_y_q  <= '0;
      prev_left_q <= 1'b0;
      press_q     <= 1'b0;
      click_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      cell_x_q    <= '0;
      cell_y_q    <= '0;
    end else begin
      vblnk_q <= vblnk_i;
      press_q <= press_d;
      click_q <= vblank_rise & press_q;
      if (mouse_valid_i) begin
        shadow_x_q  <= mouse_x_i;
        shadow_y_q  <= mouse_y_i;
        prev_left_q <= mouse_left_i;
      end
      if (commit) begin
        x_q      <= clamp_x;
        y_q      <= clamp_y;
        cell_x_q <= clamp_cell_x;
        cell_y_q <= clamp_cell_y;
      end
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign cell_x_o = cell_x_q;
  assign cell_y_o = cell_y_q;
  assign click_o  = click_q;

endmodule

// File: tb/tb_mouse_frame_latch.sv
// Directed bench for mouse_frame_latch: inputs change and outputs are sampled
// on the falling clock edge, away from the active rising edge.
module tb_mouse_frame_latch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] mouse_x_i = '0;
  logic [11:0] mouse_y_i = '0;
  logic        mouse_valid_i = 1'b0;
  logic        mouse_left_i = 1'b0;
  logic        vblnk_i = 1'b0;
  logic [11:0] x_o, y_o, cell_x_o, cell_y_o;
  logic        click_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mouse_frame_latch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mouse_x_i     (mouse_x_i),
    .mouse_y_i     (mouse_y_i),
    .mouse_valid_i (mouse_valid_i),
    .mouse_left_i  (mouse_left_i),
    .vblnk_i       (vblnk_i),
    .x_o           (x_o),
    .y_o           (y_o),
    .cell_x_o      (cell_x_o),
    .cell_y_o      (cell_y_o),
    .click_o       (click_o)
  );

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_sample(input logic [11:0] x, input logic [11:0] y, input logic left);
    @(negedge clk);
    mouse_x_i     = x;
    mouse_y_i     = y;
    mouse_left_i  = left;
    mouse_valid_i = 1'b1;
    @(negedge clk);
    mouse_valid_i = 1'b0;
  endtask

  // One full vertical blank; returns how many cycles click_o was seen high.
  task automatic vblank_frame(output int clicks);
    clicks = 0;
    @(negedge clk);
    vblnk_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (click_o === 1'b1) clicks++;
    end
    vblnk_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (click_o === 1'b1) clicks++;
    end
  endtask

  task automatic test_reset;
    int clicks;
    rst_n = 1'b0;
    idle_cycles(2);
    total++;
    if ({x_o, y_o, cell_x_o, cell_y_o, click_o} !== 49'd0) begin
      bad++;
      $display("FAIL reset_outputs: got x=%0d y=%0d cx=%0d cy=%0d click=%b, want all zero",
               x_o, y_o, cell_x_o, cell_y_o, click_o);
    end
    rst_n = 1'b1;
    idle_cycles(3);
    for (int f = 0; f < 3; f++) begin
      vblank_frame(clicks);
      total++;
      if (x_o !== 12'd0 || y_o !== 12'd0 || clicks != 0) begin
        bad++;
        $display("FAIL idle_frame%0d: got x=%0d y=%0d clicks=%0d, want x=0 y=0 clicks=0",
                 f, x_o, y_o, clicks);
      end
    end
  endtask

  task automatic test_commit_latency;
    send_sample(12'd300, 12'd200, 1'b0);
    idle_cycles(3);
    total++;
    if (x_o !== 12'd0 || y_o !== 12'd0) begin
      bad++;
      $display("FAIL commit_held_midframe: got x=%0d y=%0d, want x=0 y=0", x_o, y_o);
    end
    @(negedge clk);
    vblnk_i = 1'b1;
    @(negedge clk);
    total++;
    if (x_o !== 12'd300 || y_o !== 12'd200 || cell_x_o !== 12'd18 || cell_y_o !== 12'd12) begin
      bad++;
      $display("FAIL commit_one_cycle: got x=%0d y=%0d cx=%0d cy=%0d, want 300 200 18 12",
               x_o, y_o, cell_x_o, cell_y_o);
    end
    idle_cycles(3);
    vblnk_i = 1'b0;
    idle_cycles(3);
  endtask

  task automatic test_clamp;
    int clicks;
    send_sample(12'd2000, 12'd900, 1'b0);
    idle_cycles(2);
    send_sample(12'd1500, 12'd4095, 1'b0);
    vblank_frame(clicks);
    total++;
    if (x_o !== 12'd1023 || y_o !== 12'd767 || cell_x_o !== 12'd63 || cell_y_o !== 12'd47) begin
      bad++;
      $display("FAIL clamp_max: got x=%0d y=%0d cx=%0d cy=%0d, want 1023 767 63 47",
               x_o, y_o, cell_x_o, cell_y_o);
    end
    send_sample(12'd1024, 12'd768, 1'b0);
    send_sample(12'd1022, 12'd766, 1'b0);
    vblank_frame(clicks);
    total++;
    if (x_o !== 12'd1022 || y_o !== 12'd766 || cell_x_o !== 12'd63 || cell_y_o !== 12'd47) begin
      bad++;
      $display("FAIL clamp_inside_last_wins: got x=%0d y=%0d cx=%0d cy=%0d, want 1022 766 63 47",
               x_o, y_o, cell_x_o, cell_y_o);
    end
    send_sample(12'd1024, 12'd768, 1'b0);
    vblank_frame(clicks);
    total++;
    if (x_o !== 12'd1023 || y_o !== 12'd767) begin
      bad++;
      $display("FAIL clamp_edge: got x=%0d y=%0d, want 1023 767", x_o, y_o);
    end
  endtask

  task automatic test_click;
    int clicks;
    send_sample(12'd40, 12'd41, 1'b1);
    send_sample(12'd42, 12'd43, 1'b0);
    send_sample(12'd44, 12'd45, 1'b1);
    vblank_frame(clicks);
    total++;
    if (clicks != 1 || x_o !== 12'd44 || y_o !== 12'd45) begin
      bad++;
      $display("FAIL click_collapse: got clicks=%0d x=%0d y=%0d, want clicks=1 x=44 y=45",
               clicks, x_o, y_o);
    end
    vblank_frame(clicks);
    total++;
    if (clicks != 0) begin
      bad++;
      $display("FAIL click_quiet_frame: got clicks=%0d, want 0", clicks);
    end
    // Button held down across samples is not a fresh press.
    send_sample(12'd46, 12'd47, 1'b1);
    vblank_frame(clicks);
    total++;
    if (clicks != 0) begin
      bad++;
      $display("FAIL click_held_no_edge: got clicks=%0d, want 0", clicks);
    end
    send_sample(12'd46, 12'd47, 1'b0);
    vblank_frame(clicks);
  endtask

  task automatic test_back_to_back;
    int clicks;
    send_sample(12'd10, 12'd20, 1'b0);
    idle_cycles(2);
    @(negedge clk);
    vblnk_i       = 1'b1;
    mouse_valid_i = 1'b1;
    mouse_x_i     = 12'd50;
    mouse_y_i     = 12'd60;
    mouse_left_i  = 1'b1;
    @(negedge clk);
    mouse_valid_i = 1'b0;
    total++;
    if (x_o !== 12'd10 || y_o !== 12'd20 || click_o !== 1'b0) begin
      bad++;
      $display("FAIL same_cycle_commit_old: got x=%0d y=%0d click=%b, want 10 20 0",
               x_o, y_o, click_o);
    end
    idle_cycles(3);
    vblnk_i = 1'b0;
    idle_cycles(3);
    vblank_frame(clicks);
    total++;
    if (x_o !== 12'd50 || y_o !== 12'd60 || clicks != 1) begin
      bad++;
      $display("FAIL same_cycle_next_frame: got x=%0d y=%0d clicks=%0d, want 50 60 1",
               x_o, y_o, clicks);
    end
  endtask

  task automatic test_reset_mid_frame;
    int clicks;
    send_sample(12'd100, 12'd100, 1'b0);
    send_sample(12'd110, 12'd110, 1'b1);
    @(negedge clk);
    vblnk_i = 1'b1;
    rst_n   = 1'b0;
    #1;
    total++;
    if ({x_o, y_o, cell_x_o, cell_y_o, click_o} !== 49'd0) begin
      bad++;
      $display("FAIL async_reset_clears: got x=%0d y=%0d cx=%0d cy=%0d click=%b, want all zero",
               x_o, y_o, cell_x_o, cell_y_o, click_o);
    end
    idle_cycles(2);
    rst_n = 1'b1;
    clicks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (click_o === 1'b1) clicks++;
    end
    total++;
    if (x_o !== 12'd0 || y_o !== 12'd0 || clicks != 0) begin
      bad++;
      $display("FAIL release_no_commit: got x=%0d y=%0d clicks=%0d, want 0 0 0", x_o, y_o, clicks);
    end
    vblnk_i = 1'b0;
    idle_cycles(3);
    vblank_frame(clicks);
    total++;
    if (x_o !== 12'd0 || y_o !== 12'd0 || clicks != 0) begin
      bad++;
      $display("FAIL post_reset_idle_frame: got x=%0d y=%0d clicks=%0d, want 0 0 0",
               x_o, y_o, clicks);
    end
    send_sample(12'd5, 12'd6, 1'b0);
    vblank_frame(clicks);
    total++;
    if (x_o !== 12'd5 || y_o !== 12'd6 || cell_x_o !== 12'd0 || cell_y_o !== 12'd0) begin
      bad++;
      $display("FAIL post_reset_commit: got x=%0d y=%0d cx=%0d cy=%0d, want 5 6 0 0",
               x_o, y_o, cell_x_o, cell_y_o);
    end
  endtask

  initial begin
    test_reset();
    test_commit_latency();
    test_clamp();
    test_click();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
